// File: rtl/link_pkg.sv
// Definitions shared by both ends of the UART link: line levels, the tx state
// encoding and the default baud divider used by the sampling receiver.
package link_pkg;

   localparam logic UART_START = 1'b0;
   localparam logic UART_STOP  = 1'b1;

   localparam int DEFAULT_CLKS_PER_BIT = 16;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } tx_state_t;

endpackage

// File: rtl/byte_fifo.sv
// Small synchronous byte FIFO with a zero-latency head (dout shows the oldest entry).
// A push into a full FIFO only succeeds if a pop frees a slot on the same edge.
module byte_fifo #(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  logic [7:0]               din,
   input  logic                     pop,
   output logic [7:0]               dout,
   output logic [$clog2(DEPTH):0]   level,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [AW:0]   level_reg;
   logic          wr_en, rd_en;

   assign full  = (level_reg == (AW+1)'(DEPTH));
   assign empty = (level_reg == '0);
   assign wr_en = push && (!full || pop);
   assign rd_en = pop && !empty;
   assign dout  = mem[rd_ptr_reg];
   assign level = level_reg;

   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem[wr_ptr_reg] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         level_reg  <= '0;
      end else begin
         if (wr_en) begin
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         end
         if (rd_en) begin
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         end
         if (wr_en && !rd_en) begin
            level_reg <= level_reg + (AW+1)'(1);
         end else if (rd_en && !wr_en) begin
            level_reg <= level_reg - (AW+1)'(1);
         end
      end
   end

endmodule

// File: rtl/uart_bit_tx.sv
// Packs the decoder's recovered bit stream LSB-first into bytes, queues them and
// sends each one as an 8N1 UART frame toward the host.
module uart_bit_tx
   import link_pkg::*;
#(
   parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
   parameter int FIFO_DEPTH   = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          valid_in,
   input  logic                          bit_in,
   input  logic                          flush,
   output logic                          tx,
   output logic                          tx_busy,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          overflow
);

   localparam int              BW       = $clog2(CLKS_PER_BIT);
   localparam logic [BW-1:0]   BAUD_MAX = BW'(CLKS_PER_BIT - 1);

   // Packer: bits above count stay zero because the register clears on every push,
   // which makes flush padding free.
   logic [7:0] pack_reg, pack_next, pack_fill;
   logic [2:0] count_reg, count_next;
   logic [3:0] fill_count;
   logic       push;

   always_comb begin
      pack_fill = pack_reg;
      if (valid_in) begin
         pack_fill[count_reg] = bit_in;
      end
      fill_count = {1'b0, count_reg} + {3'b000, valid_in};
      push       = (fill_count == 4'd8) || (flush && (fill_count != 4'd0));
      pack_next  = push ? 8'h00 : pack_fill;
      count_next = push ? 3'd0 : fill_count[2:0];
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         pack_reg  <= '0;
         count_reg <= '0;
      end else begin
         pack_reg  <= pack_next;
         count_reg <= count_next;
      end
   end

   logic [7:0] fifo_dout;
   logic       fifo_full, fifo_empty;
   logic       pop;

   byte_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .din   (pack_fill),
      .pop   (pop),
      .dout  (fifo_dout),
      .level (fifo_level),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   logic overflow_reg;

   always_ff @(posedge clk) begin
      if (!reset) begin
         overflow_reg <= 1'b0;
      end else if (push && fifo_full && !pop) begin
         overflow_reg <= 1'b1;
      end
   end

   assign overflow = overflow_reg;

   // Transmit FSM
   tx_state_t     state_reg, state_next;
   logic [BW-1:0] baud_reg, baud_next;
   logic [2:0]    bit_reg, bit_next;
   logic [7:0]    shift_reg, shift_next;
   logic          tx_reg, tx_next;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_reg <= IDLE;
         baud_reg  <= '0;
         bit_reg   <= '0;
         shift_reg <= '0;
         tx_reg    <= UART_STOP;
      end else begin
         state_reg <= state_next;
         baud_reg  <= baud_next;
         bit_reg   <= bit_next;
         shift_reg <= shift_next;
         tx_reg    <= tx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      baud_next  = baud_reg + BW'(1);
      bit_next   = bit_reg;
      shift_next = shift_reg;
      pop        = 1'b0;
      unique case (state_reg)
         IDLE: begin
            baud_next = '0;
            if (!fifo_empty) begin
               pop        = 1'b1;
               shift_next = fifo_dout;
               bit_next   = '0;
               state_next = START;
            end
         end
         START: begin
            if (baud_reg == BAUD_MAX) begin
               baud_next  = '0;
               state_next = DATA;
            end
         end
         DATA: begin
            if (baud_reg == BAUD_MAX) begin
               baud_next  = '0;
               shift_next = {1'b0, shift_reg[7:1]};
               if (bit_reg == 3'd7) begin
                  state_next = STOP;
               end else begin
                  bit_next = bit_reg + 3'd1;
               end
            end
         end
         STOP: begin
            if (baud_reg == BAUD_MAX) begin
               baud_next  = '0;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Line level is derived from the next state so tx itself is a plain flop.
   always_comb begin
      tx_next = UART_STOP;
      if (state_next == START) begin
         tx_next = UART_START;
      end else if (state_next == DATA) begin
         tx_next = shift_next[0];
      end
   end

   assign tx      = tx_reg;
   assign tx_busy = (state_reg != IDLE);

endmodule
